dh_exp_scheduler: RTL and testbench

Shares a single modular-exponentiation engine between two requesters (party A and party B of the key exchange). It accepts one job per requester, arbitrates round-robin, and sequences the engine's level-start/done protocol. It returns each 64-bit result to the requester that owns it. It sits between the two party controllers and the one exponentiation instance in the key-exchange top level.

---
 rtl/dh_exp_scheduler_if.sv | 43 ++++
 rtl/dh_exp_scheduler.sv | 144 ++++++++++++++
 tb/tb_dh_exp_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dh_exp_scheduler_if.sv
// rtl/dh_exp_scheduler_if.sv - Signal bundle between the party controllers, the scheduler and the exponentiation engine
// Party A/B: req/base/exp toward the scheduler, ack/res/vld/err back to the party.
// Engine:    eng_start/eng_base/eng_exponent toward the engine, eng_result/eng_done back.
// Status:    busy, owner from the scheduler.
// master: party controllers plus engine; slave: the scheduler.
interface dh_exp_scheduler_if;
    logic        req_a;
    logic [63:0] base_a;
    logic [31:0] exp_a;
    logic        ack_a;
    logic [63:0] res_a;
    logic        vld_a;
    logic        err_a;

    logic        req_b;
    logic [63:0] base_b;
    logic [31:0] exp_b;
    logic        ack_b;
    logic [63:0] res_b;
    logic        vld_b;
    logic        err_b;

    logic        eng_start;
    logic [63:0] eng_base;
    logic [31:0] eng_exponent;
    logic [63:0] eng_result;
    logic        eng_done;

    logic        busy;
    logic        owner;

    modport master (
        output req_a, base_a, exp_a, req_b, base_b, exp_b, eng_result, eng_done,
        input  ack_a, res_a, vld_a, err_a, ack_b, res_b, vld_b, err_b,
        input  eng_start, eng_base, eng_exponent, busy, owner
    );

    modport slave (
        input  req_a, base_a, exp_a, req_b, base_b, exp_b, eng_result, eng_done,
        output ack_a, res_a, vld_a, err_a, ack_b, res_b, vld_b, err_b,
        output eng_start, eng_base, eng_exponent, busy, owner
    );
endinterface

// File: rtl/dh_exp_scheduler.sv
// rtl/dh_exp_scheduler.sv - Round-robin sharing of one modular-exponentiation engine between DH parties A and B
// clk : system clock, rising edge.
// rst : asynchronous active-low reset.
// bus : party A/B request/result channels, engine start/operand/result channel, busy/owner status.
// TIMEOUT : watchdog limit in cycles per engine job, 0 disables the watchdog.
module dh_exp_scheduler #(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst,
    dh_exp_scheduler_if.slave  bus
);

    localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t      state_q;
    logic        last_owner_q;
    logic        owner_q;
    logic        eng_start_q;
    logic        busy_q;
    logic        ack_a_q;
    logic        ack_b_q;
    logic        vld_a_q;
    logic        vld_b_q;
    logic        err_a_q;
    logic        err_b_q;
    logic [63:0] res_a_q;
    logic [63:0] res_b_q;
    logic [63:0] eng_base_q;
    logic [31:0] eng_exp_q;
    logic [31:0] wdog_q;

    logic [31:0] wdog_d;
    logic        timeout_d;
    logic        grant_b_d;

    always_comb begin
        // The counter never passes TIMEOUT because the job leaves RUN
        // the cycle it gets there; the hold only matters for TIMEOUT=0.
        wdog_d    = (wdog_q == TIMEOUT_W) ? wdog_q : wdog_q + 32'd1;
        // The current RUN cycle is counted, so the abort fires on the
        // TIMEOUT-th cycle with eng_start high.
        timeout_d = (TIMEOUT_W != 32'd0) && (wdog_d == TIMEOUT_W);
        // B wins when alone, or on a tie when A was served last.
        grant_b_d = bus.req_b && (!bus.req_a || !last_owner_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            eng_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            vld_a_q      <= 1'b0;
            vld_b_q      <= 1'b0;
            err_a_q      <= 1'b0;
            err_b_q      <= 1'b0;
            res_a_q      <= 64'd0;
            res_b_q      <= 64'd0;
            eng_base_q   <= 64'd0;
            eng_exp_q    <= 32'd0;
            wdog_q       <= 32'd0;
        end else begin
            ack_a_q <= 1'b0;
            ack_b_q <= 1'b0;
            vld_a_q <= 1'b0;
            vld_b_q <= 1'b0;
            err_a_q <= 1'b0;
            err_b_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (bus.req_a || bus.req_b) begin
                        owner_q     <= grant_b_d;
                        eng_base_q  <= grant_b_d ? bus.base_b : bus.base_a;
                        eng_exp_q   <= grant_b_d ? bus.exp_b  : bus.exp_a;
                        ack_a_q     <= !grant_b_d;
                        ack_b_q     <= grant_b_d;
                        eng_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        wdog_q      <= 32'd0;
                        state_q     <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    wdog_q <= wdog_d;
                    // Completion takes priority over a coincident timeout.
                    if (bus.eng_done) begin
                        if (owner_q) begin
                            res_b_q <= bus.eng_result;
                            vld_b_q <= 1'b1;
                        end else begin
                            res_a_q <= bus.eng_result;
                            vld_a_q <= 1'b1;
                        end
                        eng_start_q <= 1'b0;
                        state_q     <= ST_RELEASE;
                    end else if (timeout_d) begin
                        err_a_q     <= !owner_q;
                        err_b_q     <= owner_q;
                        eng_start_q <= 1'b0;
                        state_q     <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    // One cycle with eng_start low lets the engine clear itself.
                    last_owner_q <= owner_q;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack_a        = ack_a_q;
    assign bus.ack_b        = ack_b_q;
    assign bus.vld_a        = vld_a_q;
    assign bus.vld_b        = vld_b_q;
    assign bus.err_a        = err_a_q;
    assign bus.err_b        = err_b_q;
    assign bus.res_a        = res_a_q;
    assign bus.res_b        = res_b_q;
    assign bus.eng_start    = eng_start_q;
    assign bus.eng_base     = eng_base_q;
    assign bus.eng_exponent = eng_exp_q;
    assign bus.busy         = busy_q;
    assign bus.owner        = owner_q;

endmodule

// File: tb/tb_dh_exp_scheduler.sv
// tb/tb_dh_exp_scheduler.sv - Self-checking bench for dh_exp_scheduler
module tb_dh_exp_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dh_exp_scheduler_if if0();
    dh_exp_scheduler_if if1();
    dh_exp_scheduler_if if2();

    dh_exp_scheduler #(.TIMEOUT(4096)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    dh_exp_scheduler #(.TIMEOUT(8))    u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    dh_exp_scheduler #(.TIMEOUT(6))    u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    function automatic logic [63:0] ipow(input logic [63:0] b, input logic [31:0] e);
        logic [63:0] r;
        logic [63:0] x;
        r = 64'd1;
        x = b;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = r * x;
            x = x * x;
        end
        return r;
    endfunction

    // Engine model: done on the (exponent+2)-th cycle of eng_start high.
    logic [31:0] ecnt0;
    logic [31:0] ecnt2;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ecnt0 <= 32'd0;
            ecnt2 <= 32'd0;
        end else begin
            ecnt0 <= if0.eng_start ? ecnt0 + 32'd1 : 32'd0;
            ecnt2 <= if2.eng_start ? ecnt2 + 32'd1 : 32'd0;
        end
    end
    assign if0.eng_done   = if0.eng_start && (ecnt0 >= if0.eng_exponent + 32'd1);
    assign if0.eng_result = ipow(if0.eng_base, if0.eng_exponent);
    assign if2.eng_done   = if2.eng_start && (ecnt2 >= if2.eng_exponent + 32'd1);
    assign if2.eng_result = ipow(if2.eng_base, if2.eng_exponent);
    assign if1.eng_done   = 1'b0;
    assign if1.eng_result = 64'hDEAD_BEEF_0BAD_F00D;

    typedef struct { int dut; int party; logic err; logic [63:0] res; } sb_t;
    typedef struct { int dut; int party; } gr_t;
    typedef struct { int party; logic [63:0] base; logic [31:0] e; logic [63:0] res; int start_cycles; } vec_t;

    sb_t sbq[$];
    gr_t gq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          jobs[3][2];
    logic [63:0] base_in[3][2];
    logic [31:0] exp_in[3][2];
    int n_ack[3][2];
    int n_vld[3][2];
    int n_err[3][2];
    int t_ack[3][2];
    int t_vld[3][2];
    int t_err[3][2];
    int n_start[3];
    int n_ev[3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive();
        if0.req_a = jobs[0][0] > 0; if0.base_a = base_in[0][0]; if0.exp_a = exp_in[0][0];
        if0.req_b = jobs[0][1] > 0; if0.base_b = base_in[0][1]; if0.exp_b = exp_in[0][1];
        if1.req_a = jobs[1][0] > 0; if1.base_a = base_in[1][0]; if1.exp_a = exp_in[1][0];
        if1.req_b = jobs[1][1] > 0; if1.base_b = base_in[1][1]; if1.exp_b = exp_in[1][1];
        if2.req_a = jobs[2][0] > 0; if2.base_a = base_in[2][0]; if2.exp_a = exp_in[2][0];
        if2.req_b = jobs[2][1] > 0; if2.base_b = base_in[2][1]; if2.exp_b = exp_in[2][1];
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 3; k++) begin
            n_start[k] = 0;
            n_ev[k] = 0;
            for (int p = 0; p < 2; p++) begin
                n_ack[k][p] = 0; n_vld[k][p] = 0; n_err[k][p] = 0;
                t_ack[k][p] = 0; t_vld[k][p] = 0; t_err[k][p] = 0;
            end
        end
    endtask

    task automatic observe(input int k, input logic [1:0] ack, input logic [1:0] vld,
                           input logic [1:0] err, input logic start, input logic own,
                           input logic [63:0] ra, input logic [63:0] rb,
                           input logic [63:0] ebase, input logic [31:0] eexp);
        sb_t e;
        gr_t g;
        if (start) n_start[k]++;
        for (int p = 0; p < 2; p++) begin
            if (ack[p]) begin
                n_ack[k][p]++;
                t_ack[k][p] = cyc;
                check("owner_at_ack", 64'(own), 64'(p));
                check("eng_base_at_ack", ebase, base_in[k][p]);
                check("eng_exp_at_ack", 64'(eexp), 64'(exp_in[k][p]));
                if (gq.size() == 0) begin
                    check("grant_unexpected", 64'(gq.size()), 64'd1);
                end else begin
                    g = gq.pop_front();
                    check("grant_dut", 64'(k), 64'(g.dut));
                    check("grant_party", 64'(p), 64'(g.party));
                end
            end
            if (vld[p] || err[p]) begin
                n_ev[k]++;
                if (vld[p]) begin n_vld[k][p]++; t_vld[k][p] = cyc; end
                if (err[p]) begin n_err[k][p]++; t_err[k][p] = cyc; end
                check("vld_err_exclusive", 64'(vld[p] & err[p]), 64'd0);
                if (sbq.size() == 0) begin
                    check("completion_unexpected", 64'(sbq.size()), 64'd1);
                end else begin
                    e = sbq.pop_front();
                    check("done_dut", 64'(k), 64'(e.dut));
                    check("done_party", 64'(p), 64'(e.party));
                    check("done_is_err", 64'(err[p]), 64'(e.err));
                    check("done_result", (p == 1) ? rb : ra, e.res);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        observe(0, {if0.ack_b, if0.ack_a}, {if0.vld_b, if0.vld_a}, {if0.err_b, if0.err_a},
                if0.eng_start, if0.owner, if0.res_a, if0.res_b, if0.eng_base, if0.eng_exponent);
        observe(1, {if1.ack_b, if1.ack_a}, {if1.vld_b, if1.vld_a}, {if1.err_b, if1.err_a},
                if1.eng_start, if1.owner, if1.res_a, if1.res_b, if1.eng_base, if1.eng_exponent);
        observe(2, {if2.ack_b, if2.ack_a}, {if2.vld_b, if2.vld_a}, {if2.err_b, if2.err_a},
                if2.eng_start, if2.owner, if2.res_a, if2.res_b, if2.eng_base, if2.eng_exponent);
        // A requester drops req when it sees ack; after its last job the
        // operand lines are scrambled since only the grant cycle samples them.
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (((k == 0) ? (p == 1 ? if0.ack_b : if0.ack_a) :
                     (k == 1) ? (p == 1 ? if1.ack_b : if1.ack_a) :
                                (p == 1 ? if2.ack_b : if2.ack_a)) && jobs[k][p] > 0) begin
                    jobs[k][p]--;
                    if (jobs[k][p] == 0) begin
                        base_in[k][p] = {$urandom, $urandom};
                        exp_in[k][p]  = $urandom;
                    end
                end
            end
        end
        drive();
    endtask

    task automatic wait_events(input int k, input int n, input int budget);
        int t;
        t = 0;
        while (n_ev[k] < n && t < budget) begin
            tick();
            t++;
        end
        if (n_ev[k] < n) check("wait_events_budget", 64'(n_ev[k]), 64'(n));
    endtask

    task automatic check_dut0_zero(input string tag);
        check({tag, "_eng_start"}, 64'(if0.eng_start), 64'd0);
        check({tag, "_busy"}, 64'(if0.busy), 64'd0);
        check({tag, "_owner"}, 64'(if0.owner), 64'd0);
        check({tag, "_ack"}, 64'({if0.ack_a, if0.ack_b}), 64'd0);
        check({tag, "_vld"}, 64'({if0.vld_a, if0.vld_b}), 64'd0);
        check({tag, "_err"}, 64'({if0.err_a, if0.err_b}), 64'd0);
        check({tag, "_res_a"}, if0.res_a, 64'd0);
        check({tag, "_res_b"}, if0.res_b, 64'd0);
        check({tag, "_eng_base"}, if0.eng_base, 64'd0);
        check({tag, "_eng_exponent"}, 64'(if0.eng_exponent), 64'd0);
    endtask

    task automatic do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int p = 0; p < 2; p++) begin
                jobs[k][p] = 0;
                base_in[k][p] = 64'd0;
                exp_in[k][p] = 32'd0;
            end
        end
        drive();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        clear_stats();
    endtask

    vec_t vt[6];
    int   te;

    initial begin
        vt[0] = '{0, 64'd3,          32'd4,  64'd81,                  6};
        vt[1] = '{1, 64'd7,          32'd2,  64'd49,                  4};
        vt[2] = '{0, 64'd2,          32'd0,  64'd1,                   2};
        vt[3] = '{1, 64'd10,         32'd5,  64'd100000,              7};
        vt[4] = '{0, 64'hFFFF_FFFF,  32'd2,  64'hFFFF_FFFE_0000_0001, 4};
        vt[5] = '{1, 64'd2,          32'd63, 64'h8000_0000_0000_0000, 65};

        // Reset state
        for (int k = 0; k < 3; k++)
            for (int p = 0; p < 2; p++) begin
                jobs[k][p] = 0; base_in[k][p] = 64'd0; exp_in[k][p] = 32'd0;
            end
        drive();
        clear_stats();
        tick();
        tick();
        check_dut0_zero("reset");
        rst = 1'b1;

        // Single jobs, one requester at a time
        do_reset();
        for (int i = 0; i < 6; i++) begin
            clear_stats();
            base_in[0][vt[i].party] = vt[i].base;
            exp_in[0][vt[i].party]  = vt[i].e;
            gq.push_back('{0, vt[i].party});
            sbq.push_back('{0, vt[i].party, 1'b0, vt[i].res});
            jobs[0][vt[i].party] = 1;
            drive();
            wait_events(0, 1, 150);
            tick();
            tick();
            check("tbl_ack_own", 64'(n_ack[0][vt[i].party]), 64'd1);
            check("tbl_ack_other", 64'(n_ack[0][1 - vt[i].party]), 64'd0);
            check("tbl_vld_own", 64'(n_vld[0][vt[i].party]), 64'd1);
            check("tbl_vld_other", 64'(n_vld[0][1 - vt[i].party]), 64'd0);
            check("tbl_err", 64'(n_err[0][0] + n_err[0][1]), 64'd0);
            check("tbl_start_cycles", 64'(n_start[0]), 64'(vt[i].start_cycles));
            check("tbl_latency", 64'(t_vld[0][vt[i].party] - t_ack[0][vt[i].party]), 64'(vt[i].start_cycles));
            check("tbl_busy_idle", 64'(if0.busy), 64'd0);
        end

        // Simultaneous first requests: A 2^10 first, then B 5^3
        do_reset();
        base_in[0][0] = 64'd2; exp_in[0][0] = 32'd10;
        base_in[0][1] = 64'd5; exp_in[0][1] = 32'd3;
        gq.push_back('{0, 0}); gq.push_back('{0, 1});
        sbq.push_back('{0, 0, 1'b0, 64'd1024});
        sbq.push_back('{0, 1, 1'b0, 64'd125});
        jobs[0][0] = 1; jobs[0][1] = 1;
        drive();
        wait_events(0, 2, 100);
        check("sim_turnaround", 64'(t_ack[0][1] - t_vld[0][0]), 64'd2);
        check("sim_res_a_held", if0.res_a, 64'd1024);
        check("sim_owner_final", 64'(if0.owner), 64'd1);

        // Fairness: both held for four jobs
        do_reset();
        base_in[0][0] = 64'd3; exp_in[0][0] = 32'd2;
        base_in[0][1] = 64'd2; exp_in[0][1] = 32'd3;
        for (int j = 0; j < 2; j++) begin
            gq.push_back('{0, 0}); gq.push_back('{0, 1});
            sbq.push_back('{0, 0, 1'b0, 64'd9});
            sbq.push_back('{0, 1, 1'b0, 64'd8});
        end
        jobs[0][0] = 2; jobs[0][1] = 2;
        drive();
        wait_events(0, 4, 200);
        check("fair_acks", 64'(n_ack[0][0] * 16 + n_ack[0][1]), 64'h22);

        // Watchdog, TIMEOUT=8, engine never finishes; A asks twice
        do_reset();
        base_in[1][0] = 64'd7; exp_in[1][0] = 32'd3;
        gq.push_back('{1, 0}); gq.push_back('{1, 0});
        sbq.push_back('{1, 0, 1'b1, 64'd0});
        sbq.push_back('{1, 0, 1'b1, 64'd0});
        jobs[1][0] = 2;
        drive();
        wait_events(1, 1, 50);
        te = t_err[1][0];
        check("wd_err_delay", 64'(t_err[1][0] - t_ack[1][0]), 64'd8);
        check("wd_release_start", 64'(if1.eng_start), 64'd0);
        check("wd_release_busy", 64'(if1.busy), 64'd1);
        tick();
        check("wd_idle_busy", 64'(if1.busy), 64'd0);
        check("wd_idle_start", 64'(if1.eng_start), 64'd0);
        wait_events(1, 2, 50);
        check("wd_reack_delay", 64'(t_ack[1][0] - te), 64'd2);
        check("wd_no_vld", 64'(n_vld[1][0] + n_vld[1][1]), 64'd0);
        check("wd_res_a", if1.res_a, 64'd0);

        // Done and timeout in the same cycle, TIMEOUT=6
        do_reset();
        base_in[2][0] = 64'd3; exp_in[2][0] = 32'd4;
        gq.push_back('{2, 0});
        sbq.push_back('{2, 0, 1'b0, 64'd81});
        jobs[2][0] = 1;
        drive();
        wait_events(2, 1, 50);
        tick();
        tick();
        check("col_latency", 64'(t_vld[2][0] - t_ack[2][0]), 64'd6);
        check("col_no_err", 64'(n_err[2][0] + n_err[2][1]), 64'd0);

        // Reset in the middle of a B job
        do_reset();
        base_in[0][1] = 64'd5; exp_in[0][1] = 32'd20;
        gq.push_back('{0, 1});
        jobs[0][1] = 1;
        drive();
        for (int t = 0; t < 20 && n_ack[0][1] == 0; t++) tick();
        check("rst_b_acked", 64'(n_ack[0][1]), 64'd1);
        tick();
        tick();
        check("rst_b_running", 64'(if0.eng_start), 64'd1);
        base_in[0][0] = 64'd2; exp_in[0][0] = 32'd5;
        base_in[0][1] = 64'd5; exp_in[0][1] = 32'd20;
        jobs[0][0] = 1; jobs[0][1] = 1;
        drive();
        #2;
        rst = 1'b0;
        #1;
        check_dut0_zero("midrst");
        tick();
        tick();
        gq.push_back('{0, 0}); gq.push_back('{0, 1});
        sbq.push_back('{0, 0, 1'b0, 64'd32});
        sbq.push_back('{0, 1, 1'b0, 64'd95367431640625});
        rst = 1'b1;
        wait_events(0, 2, 100);
        check("midrst_order", 64'(t_ack[0][1] > t_ack[0][0]), 64'd1);

        check("grant_queue_drained", 64'(gq.size()), 64'd0);
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
